// File: rtl/seq_det_sched.sv
// Round-robin scheduler that time-shares one serial 1011 detector among NREQ word requesters.
// Optional build macro SEQ_DET_SCHED_LSB_FIRST_EN serializes words LSB first instead of MSB first.
module seq_det_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic                  det_clr,
  output logic                  det_inp,
  input  logic                  det_hit,
  output logic                  busy,
  output logic                  done,
  output logic [ID_W-1:0]       done_id,
  output logic [CNT_W-1:0]      hit_cnt
);

  localparam int BIT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, REPORT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  cur_id;
  logic [BIT_W-1:0] bit_cnt;
  logic             hit_en;

  logic             pick_vld;
  logic [ID_W-1:0]  pick_id;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_nxt;

  // Scan downwards so the requester closest after ptr overwrites the others.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + 1 + k) % NREQ;
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(idx);
      end
    end
  end

`ifdef SEQ_DET_SCHED_LSB_FIRST_EN
  assign next_bit  = shreg[0];
  assign shreg_nxt = shreg >> 1;
`else
  assign next_bit  = shreg[WIDTH-1];
  assign shreg_nxt = shreg << 1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      ptr     <= ID_W'(NREQ - 1);
      cur_id  <= '0;
      bit_cnt <= '0;
      hit_en  <= 1'b0;
      gnt     <= '0;
      det_clr <= 1'b0;
      det_inp <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      hit_cnt <= '0;
    end else begin
      gnt     <= '0;
      det_clr <= 1'b0;
      done    <= 1'b0;
      // The detector output lags its input by one clock, so the hit window trails SHIFT by one.
      hit_en  <= (state == SHIFT);
      if (hit_en && det_hit && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (pick_vld) begin
            shreg   <= data[pick_id*WIDTH +: WIDTH];
            cur_id  <= pick_id;
            ptr     <= pick_id;
            gnt     <= NREQ'(1) << pick_id;
            det_clr <= 1'b1;
            hit_cnt <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          det_inp <= next_bit;
          shreg   <= shreg_nxt;
          bit_cnt <= BIT_W'(1);
          state   <= SHIFT;
        end
        SHIFT: begin
          if (bit_cnt == BIT_W'(WIDTH)) begin
            det_inp <= 1'b0;
            state   <= DRAIN;
          end else begin
            det_inp <= next_bit;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DRAIN: begin
          done    <= 1'b1;
          done_id <= cur_id;
          state   <= REPORT;
        end
        REPORT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: attaches a behavioural 1011 detector, scoreboards done_id/hit_cnt,
// checks grant, serial stream, busy/done timing, reset abort and round-robin order.
module tb_seq_det_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;
  localparam int CNT_W = 4;
  localparam int EW    = ID_W + CNT_W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] data = '0;
  logic [NREQ-1:0]       gnt;
  logic                  det_clr;
  logic                  det_inp;
  logic                  det_hit;
  logic                  busy;
  logic                  done;
  logic [ID_W-1:0]       done_id;
  logic [CNT_W-1:0]      hit_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_gnt    = 0;
  logic [EW-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  seq_det_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt),
    .det_clr(det_clr), .det_inp(det_inp), .det_hit(det_hit),
    .busy(busy), .done(done), .done_id(done_id), .hit_cnt(hit_cnt)
  );

  // behavioural non-overlapping 1011 Mealy detector with registered output
  logic [1:0] dst;
  logic       model_hit;
  logic       force_hit = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dst       <= 2'd0;
      model_hit <= 1'b0;
    end else if (det_clr) begin
      dst       <= 2'd0;
      model_hit <= 1'b0;
    end else begin
      model_hit <= (dst == 2'd3) && det_inp;
      case (dst)
        2'd0: dst <= det_inp ? 2'd1 : 2'd0;
        2'd1: dst <= det_inp ? 2'd1 : 2'd2;
        2'd2: dst <= det_inp ? 2'd3 : 2'd0;
        default: dst <= det_inp ? 2'd0 : 2'd2;
      endcase
    end
  end

  assign det_hit = force_hit | model_hit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic stream_bit(input logic [WIDTH-1:0] w, input int i);
`ifdef SEQ_DET_SCHED_LSB_FIRST_EN
    return w[i];
`else
    return w[WIDTH-1-i];
`endif
  endfunction

  function automatic logic [CNT_W-1:0] exp_hits(input logic [WIDTH-1:0] w, input bit forced);
    int c = 0;
    int i = 0;
    if (forced) c = WIDTH;
    else begin
      while (i + 3 < WIDTH) begin
        if (stream_bit(w, i) && !stream_bit(w, i+1) && stream_bit(w, i+2) && stream_bit(w, i+3)) begin
          c++;
          i += 4;
        end else begin
          i++;
        end
      end
    end
    if (c > (2**CNT_W) - 1) c = (2**CNT_W) - 1;
    return CNT_W'(c);
  endfunction

  // scoreboard: grant must match the head entry, done pops it
  always @(negedge clk) begin
    if (rst) begin
      if (gnt != '0) begin
        n_gnt++;
        if (exp_q.size() == 0) chk("gnt_unexpected", gnt, 0);
        else chk("gnt_vs_queue", gnt, 32'(1) << exp_q[0][EW-1:CNT_W]);
      end
      if (done) begin
        if (exp_q.size() == 0) chk("done_unexpected", done, 0);
        else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("done_id", done_id, e[EW-1:CNT_W]);
          chk("hit_cnt", hit_cnt, e[CNT_W-1:0]);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_done_id"}, done_id, 0);
    chk({tag, "_hit_cnt"}, hit_cnt, 0);
    chk({tag, "_det_clr"}, det_clr, 0);
    chk({tag, "_det_inp"}, det_inp, 0);
  endtask

  // one full service from an IDLE negedge (cycle 0) to the following IDLE (cycle WIDTH+4)
  task automatic serve(input int idx, input logic [WIDTH-1:0] w, input bit forced);
    data[idx*WIDTH +: WIDTH] = w;
    exp_q.push_back({ID_W'(idx), exp_hits(w, forced)});
    req = NREQ'(1) << idx;
    @(negedge clk);
    chk("gnt_c1", gnt, 32'(1) << idx);
    chk("det_clr_c1", det_clr, 1);
    chk("hit_cnt_clr_c1", hit_cnt, 0);
    req = '0;
    for (int c = 1; c <= WIDTH + 3; c++) begin
      if (c > 1) @(negedge clk);
      chk("busy_active", busy, 1);
      chk("done_timing", done, (c == WIDTH + 3) ? 1 : 0);
      if (c >= 2 && c <= WIDTH + 1) chk("det_inp_bit", det_inp, stream_bit(w, c - 2));
      if (c == WIDTH + 2) chk("det_inp_drain", det_inp, 0);
    end
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("done_idle", done, 0);
  endtask

  initial begin
    int t;
    int g0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    serve(0, 8'b1011_0000, 1'b0);
    serve(2, 8'b1011_1011, 1'b0);
    serve(3, 8'b0000_1011, 1'b0);
    force_hit = 1'b1;
    serve(1, WIDTH'($urandom), 1'b1);
    force_hit = 1'b0;
    for (int k = 0; k < 4; k++) serve($urandom_range(0, NREQ-1), WIDTH'($urandom), 1'b0);

    // abort mid-SHIFT at bit index 3
    data[1*WIDTH +: WIDTH] = 8'hB3;
    exp_q.push_back({ID_W'(1), CNT_W'(0)});
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy, 0);

    // all requesters held: order 0,1,2,3,0 with a fixed service period
    data = '0;
    exp_q.push_back({ID_W'(0), CNT_W'(0)});
    exp_q.push_back({ID_W'(1), CNT_W'(0)});
    exp_q.push_back({ID_W'(2), CNT_W'(0)});
    exp_q.push_back({ID_W'(3), CNT_W'(0)});
    exp_q.push_back({ID_W'(0), CNT_W'(0)});
    g0 = n_gnt;
    req = '1;
    for (int s = 0; s < 5; s++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
        if (n_gnt - g0 >= 5) req = '0;
      end while (!done && t < 3 * (WIDTH + 4));
      chk("rr_done_seen", done, 1);
      if (s > 0) chk("rr_spacing", t, WIDTH + 4);
    end
    req = '0;
    repeat (WIDTH + 6) @(negedge clk);
    chk("rr_grants", n_gnt - g0, 5);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish before 100000");
    $fatal(1, "timeout");
  end
endmodule
